// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI4-Stream merger: N slave streams share one master stream,
// with whole packets granted to one port at a time (no interleaving).
module axis_rr_arbiter #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 8,
    parameter int USER_W  = 1,
    localparam int KEEP_W = DATA_W / 8,
    localparam int IDX_W  = $clog2(N_PORTS)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [N_PORTS-1:0]           s_tvalid,
    output logic [N_PORTS-1:0]           s_tready,
    input  logic [N_PORTS-1:0]           s_tlast,
    input  logic [N_PORTS*DATA_W-1:0]    s_tdata,
    input  logic [N_PORTS*KEEP_W-1:0]    s_tkeep,
    input  logic [N_PORTS*ID_W-1:0]      s_tid,
    input  logic [N_PORTS*ID_W-1:0]      s_tdest,
    input  logic [N_PORTS*USER_W-1:0]    s_tuser,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic [DATA_W-1:0]            m_tdata,
    output logic [KEEP_W-1:0]            m_tkeep,
    output logic [ID_W-1:0]              m_tid,
    output logic [ID_W-1:0]              m_tdest,
    output logic [USER_W-1:0]            m_tuser,
    output logic [IDX_W-1:0]             grant_idx,
    output logic                         busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [IDX_W-1:0]     grant_idx_r;
    logic [IDX_W-1:0]     grant_next_s;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [IDX_W-1:0]     rr_ptr_next_s;
    logic [N_PORTS-1:0]   req_rot_s;
    logic [IDX_W:0]       cand_s;
    logic [IDX_W-1:0]     pick_s;
    logic                 pick_found_s;
    logic [N_PORTS-1:0]   grant_oh_s;
    logic                 lock_s;
    logic                 last_xfer_s;

    // Search requesters starting at rr_ptr: rotate so position 0 is rr_ptr
    always_comb begin
        req_rot_s    = N_PORTS'({s_tvalid, s_tvalid} >> rr_ptr_r);
        pick_s       = '0;
        pick_found_s = 1'b0;
        cand_s       = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (req_rot_s[k]) begin
                cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
                if (cand_s >= (IDX_W+1)'(N_PORTS)) begin
                    cand_s = cand_s - (IDX_W+1)'(N_PORTS);
                end else begin
                    cand_s = cand_s;
                end
                pick_s       = cand_s[IDX_W-1:0];
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // State, owner and round-robin pointer registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= ST_IDLE;
            grant_idx_r <= '0;
            rr_ptr_r    <= '0;
        end else begin
            state_r     <= state_s;
            grant_idx_r <= grant_next_s;
            rr_ptr_r    <= rr_ptr_next_s;
        end
    end

    // Next state: grant on any request, release only on the tlast transfer
    always_comb begin
        state_s       = state_r;
        grant_next_s  = grant_idx_r;
        rr_ptr_next_s = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_s      = ST_LOCK;
                    grant_next_s = pick_s;
                end else begin
                    state_s      = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (last_xfer_s) begin
                    state_s = ST_IDLE;
                    if (grant_idx_r == IDX_W'(N_PORTS - 1)) begin
                        rr_ptr_next_s = '0;
                    end else begin
                        rr_ptr_next_s = grant_idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = ST_LOCK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Outputs: AND-OR mux of the owning port, handshake gated by LOCK
    always_comb begin
        lock_s   = (state_r == ST_LOCK);
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tid    = '0;
        m_tdest  = '0;
        m_tuser  = '0;
        m_tlast  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            grant_oh_s[i] = (grant_idx_r == IDX_W'(i));
            m_tdata = m_tdata | (s_tdata[i*DATA_W +: DATA_W] & {DATA_W{grant_oh_s[i]}});
            m_tkeep = m_tkeep | (s_tkeep[i*KEEP_W +: KEEP_W] & {KEEP_W{grant_oh_s[i]}});
            m_tid   = m_tid   | (s_tid[i*ID_W +: ID_W]       & {ID_W{grant_oh_s[i]}});
            m_tdest = m_tdest | (s_tdest[i*ID_W +: ID_W]     & {ID_W{grant_oh_s[i]}});
            m_tuser = m_tuser | (s_tuser[i*USER_W +: USER_W] & {USER_W{grant_oh_s[i]}});
            m_tlast = m_tlast | (s_tlast[i] & grant_oh_s[i]);
        end
        m_tvalid    = lock_s & (|(s_tvalid & grant_oh_s));
        s_tready    = grant_oh_s & {N_PORTS{lock_s & m_tready}};
        last_xfer_s = m_tvalid & m_tready & m_tlast;
        grant_idx   = grant_idx_r;
        busy        = lock_s;
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized bench for axis_rr_arbiter: a packet-level round-robin model
// pushes expected beats at grant time; a monitor pops them on each transfer.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int IW = 8;
    localparam int UW = 1;

    logic             clk = 1'b0;
    logic             nrst;
    logic [N-1:0]     s_tvalid;
    logic [N-1:0]     s_tready;
    logic [N-1:0]     s_tlast;
    logic [N*DW-1:0]  s_tdata;
    logic [N*KW-1:0]  s_tkeep;
    logic [N*IW-1:0]  s_tid;
    logic [N*IW-1:0]  s_tdest;
    logic [N*UW-1:0]  s_tuser;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic [IW-1:0]    m_tid;
    logic [IW-1:0]    m_tdest;
    logic [UW-1:0]    m_tuser;
    logic [1:0]       grant_idx;
    logic             busy;

    axis_rr_arbiter #(.N_PORTS(N), .DATA_W(DW), .ID_W(IW), .USER_W(UW)) dut (
        .clk(clk), .nrst(nrst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [IW-1:0] id;
        logic [IW-1:0] dest;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t        beats [N][$];
    beat_t        exp_q [$];
    int           rd [N];
    int           mp [N];
    logic [N-1:0] hs_q = '0;
    logic [N-1:0] en_mask = '0;
    int           pv = 0;
    int           pr = 100;
    int           n_cmp = 0;
    int           n_fail = 0;

    bit           m_locked = 1'b0;
    int           m_owner = 0;
    int           m_ptr = 0;
    int           m_rem = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic gen_packet(input int p);
        beat_t b;
        int    len;
        len = $urandom_range(4, 1);
        for (int k = 0; k < len; k++) begin
            b.port = p;
            b.data = DW'($urandom);
            b.keep = KW'($urandom);
            b.id   = IW'(p);
            b.dest = IW'($urandom);
            b.user = UW'($urandom);
            b.last = (k == len - 1);
            beats[p].push_back(b);
        end
    endtask

    task automatic present(input int p);
        beat_t b;
        b = beats[p][rd[p]];
        s_tdata[p*DW +: DW] = b.data;
        s_tkeep[p*KW +: KW] = b.keep;
        s_tid[p*IW +: IW]   = b.id;
        s_tdest[p*IW +: IW] = b.dest;
        s_tuser[p*UW +: UW] = b.user;
        s_tlast[p]          = b.last;
        s_tvalid[p]         = 1'b1;
    endtask

    task automatic clear_sources();
        for (int p = 0; p < N; p++) begin
            beats[p].delete();
            rd[p] = 0;
            mp[p] = 0;
        end
    endtask

    task automatic run_phase(input logic [N-1:0] m, input int v, input int r, input int cycles);
        en_mask = m;
        pv      = v;
        pr      = r;
        repeat (cycles) @(posedge clk);
    endtask

    // Source drivers: hold a beat until accepted, then maybe offer the next
    initial begin
        bit mid;
        forever begin
            @(posedge clk);
            #1;
            if (!nrst) begin
                s_tvalid = '0;
            end else begin
                for (int p = 0; p < N; p++) begin
                    if (s_tvalid[p] && hs_q[p]) begin
                        rd[p]++;
                        s_tvalid[p] = 1'b0;
                    end
                    mid = (rd[p] > 0) && !beats[p][rd[p]-1].last;
                    if (!s_tvalid[p] && (en_mask[p] || mid) && ($urandom_range(99, 0) < pv)) begin
                        if (rd[p] >= beats[p].size()) gen_packet(p);
                        present(p);
                    end
                end
                m_tready = ($urandom_range(99, 0) < pr);
            end
        end
    end

    // Reference model: packet-level round robin over the offered requests
    initial begin
        logic [N-1:0] exp_rdy;
        int best, bd, d, k;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
                chk("rst_s_tready", 64'(s_tready), 64'(0));
                chk("rst_grant_idx", 64'(grant_idx), 64'(0));
                m_locked = 1'b0;
                m_ptr    = 0;
                m_rem    = 0;
                hs_q     = '0;
                exp_q.delete();
            end else begin
                exp_rdy = m_locked ? (N'(m_tready) << m_owner) : '0;
                chk("busy", 64'(busy), 64'(m_locked));
                if (m_locked) chk("grant_idx", 64'(grant_idx), 64'(m_owner));
                chk("m_tvalid", 64'(m_tvalid), 64'(m_locked && s_tvalid[m_owner]));
                chk("s_tready", 64'(s_tready), 64'(exp_rdy));
                hs_q = s_tvalid & s_tready;
                if (m_locked) begin
                    if (s_tvalid[m_owner] && m_tready) begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_locked = 1'b0;
                            m_ptr    = (m_owner + 1) % N;
                        end
                    end
                end else if (|s_tvalid) begin
                    best = 0;
                    bd   = N;
                    for (int p = 0; p < N; p++) begin
                        d = (p - m_ptr + N) % N;
                        if (s_tvalid[p] && d < bd) begin
                            bd   = d;
                            best = p;
                        end
                    end
                    m_locked = 1'b1;
                    m_owner  = best;
                    m_rem    = 0;
                    k        = mp[best];
                    while (1) begin
                        if (k >= beats[best].size()) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL model_sync @%0t: actual=no packet on port %0d required=packet", $time, best);
                            break;
                        end
                        exp_q.push_back(beats[best][k]);
                        m_rem++;
                        if (beats[best][k].last) break;
                        k++;
                    end
                    mp[best] = k + 1;
                end
            end
        end
    end

    // Monitor: every master-side transfer must match the next expected beat
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (nrst && m_tvalid === 1'b1 && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat @%0t: actual=data %0h required=no transfer", $time, m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_port", 64'(grant_idx), 64'(e.port));
                    chk("m_tdata", 64'(m_tdata), 64'(e.data));
                    chk("m_tkeep", 64'(m_tkeep), 64'(e.keep));
                    chk("m_tid", 64'(m_tid), 64'(e.id));
                    chk("m_tdest", 64'(m_tdest), 64'(e.dest));
                    chk("m_tuser", 64'(m_tuser), 64'(e.user));
                    chk("m_tlast", 64'(m_tlast), 64'(e.last));
                end
            end
        end
    end

    initial begin
        int w;
        nrst     = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tid    = '0;
        s_tdest  = '0;
        s_tuser  = '0;
        m_tready = 1'b0;
        clear_sources();
        repeat (4) @(posedge clk);
        #3 nrst = 1'b1;

        run_phase(4'b1111, 100, 100, 60);
        run_phase(4'b0100, 100, 100, 20);
        run_phase(4'b0100, 40, 70, 40);
        run_phase(4'b1111, 60, 60, 400);
        run_phase(4'b1001, 80, 70, 200);
        run_phase(4'b0011, 50, 50, 150);

        // Abort a packet with reset while a beat is on the master side
        en_mask = 4'b1111;
        pv      = 100;
        pr      = 100;
        w       = 0;
        while (1) begin
            @(posedge clk);
            #3;
            if (m_locked && s_tvalid[m_owner]) break;
            w++;
            if (w > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL lock_wait_timeout @%0t: actual=no active beat required=active beat", $time);
                break;
            end
        end
        nrst = 1'b0;
        #1;
        chk("async_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("async_s_tready", 64'(s_tready), 64'(0));
        chk("async_busy", 64'(busy), 64'(0));
        chk("async_grant_idx", 64'(grant_idx), 64'(0));
        s_tvalid = '0;
        clear_sources();
        en_mask = 4'b0110;
        repeat (3) @(posedge clk);
        #3 nrst = 1'b1;

        run_phase(4'b0110, 100, 100, 40);
        run_phase(4'b1111, 50, 50, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
